// File: rtl/dma_addr_router.sv
// dma_addr_router: address decoder and in-order gate for the AW and AR channels.
// Each direction decodes its address to a downstream port. It holds off a new
// request if that request would open a second port while responses are still
// pending. This keeps responses returning in issue order across ports.

// One direction (AW or AR): decode, outstanding tracking, stall and handshake gating.
module dma_addr_router_chan #(
    parameter int                                N_PORTS      = 2,
    parameter int                                ADDR_W       = 32,
    parameter int                                MAX_OUTST    = 8,
    parameter logic [N_PORTS-1:0][ADDR_W-1:0]    PORT_BASE    = '0,
    parameter logic [N_PORTS-1:0][ADDR_W-1:0]    PORT_MASK    = '0,
    parameter int                                DEFAULT_PORT = 0,
    parameter int                                SEL_W        = 1
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              valid_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              ready_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [SEL_W-1:0]  sel_o,
    output logic              decerr_o,
    input  logic              rsp_i,
    output logic [7:0]        outst_o,
    output logic              acc_err_o
);

    typedef enum logic {ST_IDLE, ST_BUSY} state_e;

    localparam logic [7:0] MAX_CNT = 8'(MAX_OUTST);

    state_e             state_q;
    logic [7:0]         cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   dec_sel;
    logic               hit;
    logic               stall;
    logic               accept;
    logic               resp;

    // Address decode: scan from the top so the lowest matching port wins.
    always_comb begin
        dec_sel = SEL_W'(DEFAULT_PORT);
        hit     = 1'b0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if ((addr_i & PORT_MASK[i]) == PORT_BASE[i]) begin
                dec_sel = SEL_W'(i);
                hit     = 1'b1;
            end
        end
    end

    // Stall a port switch while responses are pending, and stall when the window is full.
    // A response arriving in the same cycle as a full window does not free a slot until the next cycle.
    always_comb begin
        stall  = ((state_q == ST_BUSY) && (dec_sel != sel_q)) || (cnt_q == MAX_CNT);
        accept = valid_i & ready_i & ~stall;
        resp   = rsp_i & (state_q == ST_BUSY);
    end

    // Outstanding count next state; a response with nothing in flight is dropped.
    always_comb begin
        cnt_d = cnt_q;
        unique case ({accept, resp})
            2'b10:   cnt_d = cnt_q + 8'd1;
            2'b01:   cnt_d = cnt_q - 8'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // IDLE/BUSY tracking with the registered count and the port of the last accepted request.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (accept)
                sel_q <= dec_sel;
            unique case (state_q)
                ST_IDLE: if (accept) state_q <= ST_BUSY;
                ST_BUSY: if (resp && !accept && cnt_q == 8'd1) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Zero-latency handshake and select outputs.
    always_comb begin
        valid_o   = valid_i & ~stall;
        ready_o   = ready_i & ~stall;
        sel_o     = valid_i ? dec_sel : sel_q;
        decerr_o  = valid_i & ~hit;
        outst_o   = cnt_q;
        acc_err_o = accept & ~hit;
    end

endmodule

// Top: two independent channel instances plus the shared decode-error counter.
module dma_addr_router #(
    parameter int                                N_PORTS      = 2,
    parameter int                                ADDR_W       = 32,
    parameter int                                MAX_OUTST    = 8,
    parameter logic [N_PORTS-1:0][ADDR_W-1:0]    PORT_BASE    = '0,
    parameter logic [N_PORTS-1:0][ADDR_W-1:0]    PORT_MASK    = '0,
    parameter int                                DEFAULT_PORT = 0,
    localparam int                               SEL_W        = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_aw_valid,
    input  logic [ADDR_W-1:0] i_aw_addr,
    output logic              o_aw_ready,
    output logic              o_aw_valid,
    input  logic              i_aw_ready,
    output logic [SEL_W-1:0]  o_aw_sel,
    output logic              o_aw_decerr,
    input  logic              i_b_hs,
    input  logic              i_ar_valid,
    input  logic [ADDR_W-1:0] i_ar_addr,
    output logic              o_ar_ready,
    output logic              o_ar_valid,
    input  logic              i_ar_ready,
    output logic [SEL_W-1:0]  o_ar_sel,
    output logic              o_ar_decerr,
    input  logic              i_r_last_hs,
    output logic [7:0]        o_aw_outst,
    output logic [7:0]        o_ar_outst,
    output logic [15:0]       o_decerr_cnt
);

    logic        aw_acc_err, ar_acc_err;
    logic [15:0] derr_q, derr_d;
    logic [16:0] derr_sum;

    dma_addr_router_chan #(
        .N_PORTS(N_PORTS), .ADDR_W(ADDR_W), .MAX_OUTST(MAX_OUTST),
        .PORT_BASE(PORT_BASE), .PORT_MASK(PORT_MASK),
        .DEFAULT_PORT(DEFAULT_PORT), .SEL_W(SEL_W)
    ) u_aw (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .valid_i(i_aw_valid), .addr_i(i_aw_addr), .ready_o(o_aw_ready),
        .valid_o(o_aw_valid), .ready_i(i_aw_ready), .sel_o(o_aw_sel),
        .decerr_o(o_aw_decerr), .rsp_i(i_b_hs), .outst_o(o_aw_outst),
        .acc_err_o(aw_acc_err)
    );

    dma_addr_router_chan #(
        .N_PORTS(N_PORTS), .ADDR_W(ADDR_W), .MAX_OUTST(MAX_OUTST),
        .PORT_BASE(PORT_BASE), .PORT_MASK(PORT_MASK),
        .DEFAULT_PORT(DEFAULT_PORT), .SEL_W(SEL_W)
    ) u_ar (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .valid_i(i_ar_valid), .addr_i(i_ar_addr), .ready_o(o_ar_ready),
        .valid_o(o_ar_valid), .ready_i(i_ar_ready), .sel_o(o_ar_sel),
        .decerr_o(o_ar_decerr), .rsp_i(i_r_last_hs), .outst_o(o_ar_outst),
        .acc_err_o(ar_acc_err)
    );

    // Decode-error count: add both directions' accepted errors, saturating at all-ones.
    always_comb begin
        derr_sum = {1'b0, derr_q} + {15'd0, aw_acc_err} + {15'd0, ar_acc_err};
        derr_d   = derr_sum[16] ? 16'hFFFF : derr_sum[15:0];
    end

    // Decode-error counter register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            derr_q <= '0;
        else
            derr_q <= derr_d;
    end

    assign o_decerr_cnt = derr_q;

endmodule

// File: doc/dma_addr_router.md
DMA_ADDR_ROUTER -- requirements
Module: dma_addr_router

Interface
REQ-001 SHALL have parameter N_PORTS, default 2, number of downstream ports (2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter MAX_OUTST, default 8, max in-flight transactions per direction (1..255).
REQ-004 SHALL have parameter PORT_BASE, [N_PORTS][ADDR_W], default all 0, per-port region base.
REQ-005 SHALL have parameter PORT_MASK, [N_PORTS][ADDR_W], default all 0, per-port region mask.
REQ-006 SHALL have parameter DEFAULT_PORT, default 0, port for unmatched addresses.
REQ-007 SHALL have parameter SEL_W, localparam = max(1, clog2(N_PORTS)).
REQ-008 Clock and reset SHALL be: i_clk input 1 clock; i_rstn input 1 reset, asynchronous, active-low.
REQ-009 Write ports SHALL be: i_aw_valid in 1; i_aw_addr in ADDR_W; o_aw_ready out 1; o_aw_valid out 1; i_aw_ready in 1 (downstream); o_aw_sel out SEL_W; o_aw_decerr out 1.
REQ-010 Write response ports SHALL be: i_b_hs in 1, B-channel handshake (bvalid & bready).
REQ-011 Read ports SHALL be: i_ar_valid, i_ar_addr, o_ar_ready, o_ar_valid, i_ar_ready, o_ar_sel, o_ar_decerr, mirroring REQ-009.
REQ-012 Read response ports SHALL be: i_r_last_hs in 1, handshake of R beat with rlast.
REQ-013 Status ports SHALL be: o_aw_outst out 8; o_ar_outst out 8; o_decerr_cnt out 16.

Function (AW and AR are independent, identical; AW described)
REQ-014 Decode SHALL be combinational: match_i = ((i_aw_addr & PORT_MASK[i]) == PORT_BASE[i]); the lowest matching i is selected.
REQ-015 With no match, the decoded port SHALL be DEFAULT_PORT, and o_aw_decerr SHALL be 1 while i_aw_valid=1.
REQ-016 o_aw_sel SHALL equal the decoded port when i_aw_valid=1, else the registered port of the last accepted AW (sel_q).
REQ-017 The block SHALL keep an outstanding counter cnt_q: +1 on AW accept (o_aw_valid & i_aw_ready), -1 on i_b_hs, unchanged on both in the same cycle.
REQ-018 A decrement with cnt_q=0 SHALL be ignored (saturate at 0); an increment SHALL never occur at cnt_q=MAX_OUTST.
REQ-019 stall SHALL be 1 when (cnt_q!=0 and decoded port != sel_q) or cnt_q==MAX_OUTST; this enforces in-order response routing across ports.
REQ-020 The block SHALL drive o_aw_valid = i_aw_valid & ~stall and o_aw_ready = i_aw_ready & ~stall; the address handshake SHALL never complete while stalled.
REQ-021 An exception: when cnt_q==MAX_OUTST and i_b_hs=1, stall SHALL still hold for that cycle (no same-cycle reuse).
REQ-022 sel_q SHALL load the decoded port only on AW accept.
REQ-023 A stalled request SHALL keep o_aw_sel at its decoded value (valid held upstream per AXI; the address is stable).
REQ-024 State SHALL be IDLE (cnt_q=0) or BUSY(p) (cnt_q>0, port p=sel_q); BUSY returns to IDLE when the last response leaves with no new accept.
REQ-025 o_decerr_cnt SHALL increment by 1 per accepted AW or AR with decerr, +2 if both occur in the same cycle, and saturate at 0xFFFF.
REQ-026 o_aw_outst SHALL equal cnt_q zero-extended to 8 bits.
REQ-027 Zero-latency path: o_aw_valid/o_aw_ready/o_aw_sel SHALL add no register stage; counters SHALL update at the next edge.

Reset
REQ-028 Asserting i_rstn low SHALL asynchronously clear cnt_q, sel_q, and decerr count to 0 in both directions; mid-operation in-flight state SHALL be discarded.
REQ-029 During and after reset: o_aw_valid=o_ar_valid=0 when inputs are 0, o_aw_sel=o_ar_sel=0, o_*_decerr=0, status outputs=0.
REQ-030 After reset, the first request SHALL be accepted with no stall regardless of port.

Verification
REQ-031 Setup N_PORTS=2, PORT_BASE[1]=0x4000_0000, PORT_MASK[1]=0xF000_0000, PORT_BASE[0]=0x0000_0000, PORT_MASK[0]=0xF000_0000, DEFAULT_PORT=0. Stimulus: AW 0x4000_0100 accepted, then AW 0x0000_0200 -> o_aw_sel=0 with o_aw_valid=0 until i_b_hs, then accepted next cycle with o_aw_outst=1.
REQ-032 Stimulus: MAX_OUTST=2, three AR to port 1 with i_ar_ready=1 -> first two accepted, third stalls (o_ar_ready=0) until i_r_last_hs, accepted the cycle after.
REQ-033 Stimulus: AR 0x8000_0000 (no match) -> o_ar_sel=0, o_ar_decerr=1, o_decerr_cnt 0->1 on accept; simultaneous AW decerr accept -> count +2.
REQ-034 Stimulus: simultaneous AW accept and i_b_hs at cnt=1 -> cnt stays 1; i_b_hs at cnt=0 -> cnt stays 0.
REQ-035 Stimulus: reset pulse with o_aw_outst=3 -> all counters 0 immediately; next AW to any port passes same cycle.
